// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller: ramps the PWM duty output toward a latched target by a
// programmable step every programmable number of clocks, instead of jumping.
// Optional feature macro: PWM_RAMP_ABORT_EN (adds i_abort, which freezes the
// ramp at the current duty and returns to IDLE without a done pulse).
module pwm_ramp_controller #(
    parameter int DUTY_W     = 8,
    parameter int INTERVAL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic                  i_target_valid,
    input  logic [DUTY_W-1:0]     i_target_duty,
    input  logic [DUTY_W-1:0]     i_step,
    input  logic [INTERVAL_W-1:0] i_interval,
`ifdef PWM_RAMP_ABORT_EN
    input  logic                  i_abort,
`endif
    output logic [DUTY_W-1:0]     o_duty,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_target_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [INTERVAL_W-1:0] CNT_ZERO = {INTERVAL_W{1'b0}};
    localparam logic [INTERVAL_W-1:0] CNT_ONE  = {{(INTERVAL_W-1){1'b0}}, 1'b1};
    localparam logic [DUTY_W-1:0]     DUTY_ZERO = {DUTY_W{1'b0}};

    // One ramp step from cur toward tgt by min(stp, |tgt-cur|). The distance
    // is taken in DUTY_W+1 bits and the move is clamped to it, so the result
    // always lies between cur and tgt: no overshoot, no wrap at 0 or full scale.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] stp
    );
        logic [DUTY_W:0] ext_dist;
        logic [DUTY_W:0] ext_amt;
        logic            up;
        up = (tgt >= cur);
        if (up) begin
            ext_dist = {1'b0, tgt} - {1'b0, cur};
        end else begin
            ext_dist = {1'b0, cur} - {1'b0, tgt};
        end
        if ({1'b0, stp} < ext_dist) begin
            ext_amt = {1'b0, stp};
        end else begin
            ext_amt = ext_dist;
        end
        if (up) begin
            return tgt - (ext_dist[DUTY_W-1:0] - ext_amt[DUTY_W-1:0]);
        end else begin
            return tgt + (ext_dist[DUTY_W-1:0] - ext_amt[DUTY_W-1:0]);
        end
    endfunction

    state_t                r_state, w_state_nx;
    logic [DUTY_W-1:0]     r_duty, w_duty_nx;
    logic [DUTY_W-1:0]     r_target, w_target_nx;
    logic [DUTY_W-1:0]     r_step, w_step_nx;
    logic [INTERVAL_W-1:0] r_count, w_count_nx;
    logic                  r_busy, w_busy_nx;
    logic                  r_done, w_done_nx;
    logic                  r_ack, w_ack_nx;
    logic                  r_pend, w_pend_nx;   // target accepted while frozen, not yet resolved

    logic                  w_abort;
    logic [DUTY_W-1:0]     w_stepped;
    logic [DUTY_W-1:0]     w_base;
    logic [DUTY_W-1:0]     w_res_tgt;
    logic [DUTY_W-1:0]     w_res_step;

`ifdef PWM_RAMP_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    // A step coinciding with a new target is applied toward the old target first.
    assign w_stepped  = step_toward(r_duty, r_target, r_step);
    assign w_base     = (r_state == ST_STEP) ? w_stepped : r_duty;
    assign w_res_tgt  = i_target_valid ? i_target_duty : r_target;
    assign w_res_step = i_target_valid ? i_step : r_step;

    // Next-state and next-output logic for the ramp sequencer.
    always_comb begin
        w_state_nx  = r_state;
        w_duty_nx   = r_duty;
        w_target_nx = r_target;
        w_step_nx   = r_step;
        w_count_nx  = r_count;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_ack_nx    = 1'b0;
        w_pend_nx   = r_pend;
        if (w_abort) begin
            w_target_nx = r_duty;
            w_busy_nx   = 1'b0;
            w_count_nx  = CNT_ZERO;
            w_pend_nx   = 1'b0;
            w_state_nx  = ST_IDLE;
        end else if (!i_enable) begin
            if (i_target_valid) begin
                w_target_nx = i_target_duty;
                w_step_nx   = i_step;
                w_count_nx  = CNT_ZERO;
                w_ack_nx    = 1'b1;
                w_pend_nx   = 1'b1;
            end else begin
                w_pend_nx   = r_pend;
            end
        end else if (i_target_valid || r_pend) begin
            // Resolve a new (or deferred) target against the current duty.
            w_ack_nx    = i_target_valid;
            w_target_nx = w_res_tgt;
            w_step_nx   = w_res_step;
            w_pend_nx   = 1'b0;
            w_count_nx  = CNT_ZERO;
            w_duty_nx   = w_base;
            if (w_res_tgt == w_base) begin
                w_done_nx  = 1'b1;
                w_busy_nx  = 1'b0;
                w_state_nx = ST_IDLE;
            end else if (w_res_step == DUTY_ZERO) begin
                w_duty_nx  = w_res_tgt;
                w_done_nx  = 1'b1;
                w_busy_nx  = 1'b0;
                w_state_nx = ST_IDLE;
            end else begin
                w_busy_nx  = 1'b1;
                w_state_nx = ST_WAIT;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_IDLE;
                end
                ST_WAIT: begin
                    if (r_count >= i_interval) begin
                        w_count_nx = CNT_ZERO;
                        w_state_nx = ST_STEP;
                    end else begin
                        w_count_nx = r_count + CNT_ONE;
                    end
                end
                ST_STEP: begin
                    w_duty_nx = w_stepped;
                    if (w_stepped == r_target) begin
                        w_done_nx  = 1'b1;
                        w_busy_nx  = 1'b0;
                        w_state_nx = ST_IDLE;
                    end else if (i_interval == CNT_ZERO) begin
                        w_state_nx = ST_STEP;
                    end else begin
                        // The STEP cycle itself counts toward the next interval.
                        w_count_nx = CNT_ONE;
                        w_state_nx = ST_WAIT;
                    end
                end
                default: begin
                    w_busy_nx  = 1'b0;
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_duty   <= DUTY_ZERO;
            r_target <= DUTY_ZERO;
            r_step   <= DUTY_ZERO;
            r_count  <= CNT_ZERO;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ack    <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_duty   <= w_duty_nx;
            r_target <= w_target_nx;
            r_step   <= w_step_nx;
            r_count  <= w_count_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
            r_ack    <= w_ack_nx;
            r_pend   <= w_pend_nx;
        end
    end

    assign o_duty       = r_duty;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_target_ack = r_ack;

endmodule

// File: doc/pwm_ramp_controller.md
Name: pwm_ramp_controller

Overview:
- Sequences the PWM duty-cycle register so that duty changes ramp smoothly instead of jumping.
- Sits between the SPI register bank's duty output (target) and the PWM peripheral's duty input (actual).
- Steps the output duty toward a latched target by a programmable amount every programmable number of clocks.
- Reports busy/done and acknowledges every new target.

Parameters:
- DUTY_W, 8: width of duty values and step.
- INTERVAL_W, 16: width of the inter-step interval counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_enable  input  1  1 = ramp advances; 0 = freeze (duty and counter hold).
- i_target_valid  input  1  single-cycle strobe: load i_target_duty.
- i_target_duty  input  DUTY_W  requested final duty.
- i_step  input  DUTY_W  duty increment per step; 0 = jump directly.
- i_interval  input  INTERVAL_W  clocks between steps minus one; 0 = step every clock.
- o_duty  output  DUTY_W  duty driven to PWM peripheral.
- o_busy  output  1  high while o_duty != latched target.
- o_done  output  1  one-cycle pulse when o_duty reaches target.
- o_target_ack  output  1  one-cycle pulse, cycle after a target is accepted.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: o_duty=0, latched target=0, counter=0, o_busy=0, o_done=0, o_target_ack=0, state=IDLE.
- States: IDLE, WAIT, STEP.
- IDLE:
  - i_target_valid latches i_target_duty and i_step, and clears the counter. o_target_ack=1 on the next cycle.
  - If latched target == o_duty: o_done pulses on the next cycle and the block stays in IDLE.
  - Else if i_step == 0: o_duty = target on the next edge, o_done pulses that same cycle, and the block returns to IDLE.
  - Else: go to WAIT with o_busy=1.
- WAIT:
  - Counter increments each enabled cycle.
  - When counter == i_interval (sampled live), clear the counter and go to STEP.
- STEP (one cycle):
  - o_duty moves toward target by min(i_step, |target - o_duty|).
  - Compute in DUTY_W+1 bits: never overshoot, never wrap past 0 or 2^DUTY_W-1.
  - If the new o_duty == target: o_done=1 in the cycle o_duty first equals target, o_busy=0 in that same cycle, then go to IDLE.
  - Otherwise return to WAIT.
- Step latency: first duty change occurs i_interval+2 cycles after ack (1 to enter WAIT, i_interval+1 counting, STEP edge).
- New target mid-ramp (any state):
  - Latch the new target and clear the counter; ack next cycle.
  - The ramp continues from the current o_duty and direction is re-evaluated; no done pulse for the abandoned target.
  - If the new target equals the current o_duty: done pulse, go to IDLE.
- Target arriving in the same cycle as a STEP: the step is applied using the old target, then the new target is latched. The next step uses the new target.
- i_enable=0:
  - All state, counter, and o_duty hold.
  - Targets are still latched and acked, but no step or jump occurs until enable returns.
  - The done pulse for an equal target is deferred until enable.
- Reset mid-ramp: o_duty returns to 0 immediately (async), all pulses cleared.
- o_done and o_target_ack are never high for more than one consecutive cycle per event.

Optional Feature:
- Macro: PWM_RAMP_ABORT_EN.
- Defined:
  - Adds port i_abort (input, 1).
  - i_abort=1 freezes o_duty at its current value, sets latched target = o_duty, drops o_busy, and returns to IDLE with no o_done pulse.
  - i_abort has priority over i_target_valid in the same cycle.
- Undefined: no port; behaviour as above.

Test Plan:
- Reset then idle: assert rst mid-cycle -> o_duty=0, o_busy=0, no pulses for 20 cycles.
- Up-ramp: target=100, step=25, interval=3, enable=1 -> ack next cycle; o_duty sequence 25,50,75,100 spaced 4 cycles apart; o_done single pulse with o_duty=100.
- Saturating down-ramp: from 100, target=10, step=40, interval=0 -> o_duty 60,20,10 on consecutive STEPs; no wrap; done once.
- Jump and equal target: step=0, target=200 -> o_duty=200 one cycle after strobe with done. Re-send target=200 -> ack plus done, o_duty unchanged.
- Retarget and freeze:
  - Ramp 0->200 (step=10); at o_duty=50 send target=20 -> ramp reverses to 40,30,20, single done.
  - Drop enable for 10 cycles mid-ramp -> o_duty and counter hold, ramp resumes exactly.
- Abort (PWM_RAMP_ABORT_EN): during 0->200 ramp at o_duty=80, pulse i_abort together with i_target_valid -> o_duty stays 80, o_busy=0, no done, target ignored.
